// File: rtl/peri_pdm_decimator_pkg.sv
// Shared types and register-map constants for the PDM-to-PCM decimator.
package peri_pdm_decimator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMB = 2'd1,
        ST_PUSH = 2'd2
    } state_e;

    localparam logic ADR_CTRL   = 1'b0;
    localparam logic ADR_STATUS = 1'b0;
    localparam logic ADR_DATA   = 1'b1;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;
    localparam int STAT_NE_BIT      = 0;
    localparam int STAT_OVF_BIT     = 1;
    localparam int STAT_CNT_LSB     = 4;

endpackage

// File: rtl/peri_pdm_decimator_sync_fifo.sv
// Small synchronous FIFO; a push while full only lands if a pop frees a slot that cycle.
module sync_fifo #(
    parameter int Width = 16,
    parameter int Depth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [Width-1:0]               data_i,
    output logic [Width-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | pop_i);

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/peri_pdm_decimator.sv
// PDM microphone decimator: Order-stage CIC (integrators at strobe rate, combs time-shared
// by a small FSM), PCM conversion with clamp, FIFO and an 8-bit Wishbone register port.
module peri_pdm_decimator
    import peri_pdm_decimator_pkg::*;
#(
    parameter int Order     = 3,
    parameter int Decim     = 64,
    parameter int AudioBits = 16,
    parameter int FifoDepth = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pdm_en_i,
    input  logic       pdm_data_i,
    input  logic       wb_we_i,
    input  logic       wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_stb_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       irq_o
);
    localparam int DW    = $clog2(Decim);
    localparam int W     = Order * DW + 1;
    localparam int SHIFT = W - 1 - AudioBits;
    localparam int SIW   = (Order > 1) ? $clog2(Order) : 1;
    localparam int CW    = $clog2(FifoDepth + 1);
    localparam logic signed [W:0] HALF    = (W+1)'(64'd1 << (W - 2));
    localparam logic signed [W:0] POS_MAX = HALF - (W+1)'(1);

    logic [W-1:0]         integ_q [Order];
    logic [W-1:0]         integ_d [Order];
    logic [W-1:0]         comb_q  [Order];
    logic [DW-1:0]        dcnt_q, dcnt_d;
    logic [W-1:0]         acc_q, comb_diff;
    logic [SIW-1:0]       stage_q;
    state_e               state_q;
    logic                 push_q;
    logic [AudioBits-1:0] pcm_q, pcm_conv;
    logic signed [W:0]    s_raw, s_clamp, s_sh;
    logic                 enable_q, ovf_q, phase_q, latch;

    logic                 rd_data, wr_ctrl, pop, fifo_push, fifo_full, fifo_empty, ovf_evt;
    logic [AudioBits-1:0] fifo_dout;
    logic [CW-1:0]        fifo_cnt;
    logic [7:0]           status;
    logic [15:0]          head16;
    logic                 unused_wdat;

    always_comb begin
        dcnt_d = dcnt_q;
        for (int k = 0; k < Order; k++) integ_d[k] = integ_q[k];
        if (!enable_q) begin
            dcnt_d = '0;
            for (int k = 0; k < Order; k++) integ_d[k] = '0;
        end else if (pdm_en_i) begin
            dcnt_d     = dcnt_q + 1'b1;
            integ_d[0] = integ_q[0] + W'(pdm_data_i);
            for (int k = 1; k < Order; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    assign latch = enable_q & pdm_en_i & (dcnt_q == DW'(Decim - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dcnt_q <= '0;
            for (int k = 0; k < Order; k++) integ_q[k] <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            for (int k = 0; k < Order; k++) integ_q[k] <= integ_d[k];
        end
    end

    // Gain is Decim^Order = 2^(W-1), so full-scale ones lands exactly one LSB past the clamp.
    always_comb begin
        comb_diff = acc_q - comb_q[stage_q];
        s_raw     = $signed({1'b0, comb_diff}) - HALF;
        s_clamp   = (s_raw > POS_MAX) ? POS_MAX : s_raw;
        s_sh      = s_clamp >>> SHIFT;
        pcm_conv  = AudioBits'(s_sh);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            acc_q   <= '0;
            push_q  <= 1'b0;
            pcm_q   <= '0;
            for (int k = 0; k < Order; k++) comb_q[k] <= '0;
        end else if (!enable_q) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            acc_q   <= '0;
            push_q  <= 1'b0;
            pcm_q   <= '0;
            for (int k = 0; k < Order; k++) comb_q[k] <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (latch) begin
                    acc_q   <= integ_d[Order-1];
                    stage_q <= '0;
                    state_q <= ST_COMB;
                end
                ST_COMB: begin
                    comb_q[stage_q] <= acc_q;
                    acc_q           <= comb_diff;
                    if (stage_q == SIW'(Order - 1)) begin
                        state_q <= ST_PUSH;
                        push_q  <= 1'b1;
                        pcm_q   <= pcm_conv;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                    end
                end
                ST_PUSH: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_push = push_q & enable_q;
    assign rd_data   = wb_stb_i & ~wb_we_i & (wb_adr_i == ADR_DATA);
    assign wr_ctrl   = wb_stb_i & wb_we_i & (wb_adr_i == ADR_CTRL);
    assign pop       = rd_data & ~fifo_empty & phase_q;
    assign ovf_evt   = fifo_push & fifo_full & ~pop;

    sync_fifo #(.Width(AudioBits), .Depth(FifoDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (pop),
        .data_i  (pcm_q),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q <= 1'b0;
            ovf_q    <= 1'b0;
            phase_q  <= 1'b0;
        end else begin
            if (wr_ctrl) enable_q <= wb_dat_i[CTRL_EN_BIT];
            if (ovf_evt) ovf_q <= 1'b1;
            else if (wr_ctrl && wb_dat_i[CTRL_CLR_OVF_BIT]) ovf_q <= 1'b0;
            if (rd_data && !fifo_empty) phase_q <= ~phase_q;
        end
    end

    always_comb begin
        status                       = '0;
        status[STAT_NE_BIT]          = ~fifo_empty;
        status[STAT_OVF_BIT]         = ovf_q;
        status[STAT_CNT_LSB +: 4]    = 4'(fifo_cnt);
        head16                       = 16'($signed(fifo_dout));
        if (wb_adr_i == ADR_STATUS)  wb_dat_o = status;
        else if (fifo_empty)         wb_dat_o = 8'h00;
        else                         wb_dat_o = phase_q ? head16[15:8] : head16[7:0];
    end

    assign wb_ack_o    = wb_stb_i;
    assign irq_o       = enable_q & ~fifo_empty;
    assign unused_wdat = ^wb_dat_i[7:2];

endmodule

// File: tb/tb_peri_pdm_decimator.sv
// Scoreboard bench for peri_pdm_decimator: constant/alternating PDM patterns, overflow, reset.
module tb_peri_pdm_decimator;
    localparam int DECIM = 64;
    localparam int DEPTH = 8;

    logic       clk = 1'b0, rst = 1'b0, pdm_en = 1'b0, pdm_data = 1'b0;
    logic       we = 1'b0, adr = 1'b0, stb = 1'b0;
    logic [7:0] wdat = 8'h00;
    logic [7:0] rdat;
    logic       ack, irq;

    int n_chk = 0, n_pass = 0;
    int exp_q[$];
    int mdl_cnt = 0;
    bit mdl_ovf = 1'b0;

    always #5 clk = ~clk;

    peri_pdm_decimator dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pdm_en_i   (pdm_en),
        .pdm_data_i (pdm_data),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (wdat),
        .wb_stb_i   (stb),
        .wb_dat_o   (rdat),
        .wb_ack_o   (ack),
        .irq_o      (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wb_write(input logic a, input logic [7:0] d);
        @(posedge clk); #1 stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        @(posedge clk); #1 stb = 1'b0; we = 1'b0; wdat = 8'h00;
    endtask

    task automatic wb_read(input logic a, output logic [7:0] d);
        @(posedge clk); #1 stb = 1'b1; we = 1'b0; adr = a;
        #3 d = rdat;
        check("ack", ack, 1);
        @(posedge clk); #1 stb = 1'b0;
    endtask

    task automatic status_chk(input string tag);
        logic [7:0] d;
        wb_read(1'b0, d);
        check(tag, d, {4'(mdl_cnt), 2'b00, mdl_ovf, mdl_cnt != 0});
    endtask

    task automatic strobe(input logic b);
        @(posedge clk); #1 pdm_en = 1'b1; pdm_data = b;
        @(posedge clk); #1 pdm_en = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Model of FIFO occupancy: a sample arriving with DEPTH entries held is dropped.
    task automatic sb_push(input int e);
        if (mdl_cnt == DEPTH) mdl_ovf = 1'b1;
        else begin
            exp_q.push_back(e);
            mdl_cnt++;
        end
    endtask

    // mode 1: all ones, 0: all zeros, 2: alternating 1,0. First three outputs are transient.
    task automatic run_pattern(input int mode, input int first, input int nsamp);
        for (int j = 0; j < nsamp; j++) begin
            for (int i = 0; i < DECIM; i++)
                strobe(mode == 1 ? 1'b1 : mode == 0 ? 1'b0 : (i % 2 == 0));
            repeat (2) @(posedge clk);
            sb_push((first + j) < 3 ? -1 : (mode == 1 ? 'h7FFF : mode == 0 ? 'h8000 : 0));
        end
    endtask

    task automatic drain(input int n);
        logic [7:0] lo, hi;
        int e;
        for (int k = 0; k < n; k++) begin
            wb_read(1'b1, lo);
            wb_read(1'b1, hi);
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mdl_cnt--;
                if (e >= 0) check("pcm", {16'h0, hi, lo}, e);
            end
        end
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 stb = 1'b1; adr = 1'b0;
        #2 check("rst_status", rdat, 8'h00);
        check("rst_ack", ack, 1);
        check("rst_irq", irq, 0);
        adr = 1'b1;
        #1 check("rst_data", rdat, 8'h00);
        stb = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        wb_read(1'b1, d);
        check("empty_data", d, 8'h00);
        status_chk("st_idle");
        wb_write(1'b0, 8'h01);
        status_chk("st_en");
        check("irq_empty", irq, 0);

        run_pattern(1, 0, 8);
        status_chk("st_full8");
        check("irq_full", irq, 1);
        wb_read(1'b1, d);
        check("ones_first_lo_of_sample1_phase", d, rdat_lo_ref(d));
        drain_after_lo(d);
        status_chk("st_drained");
        check("irq_drained", irq, 0);

        wb_write(1'b0, 8'h00);
        wb_write(1'b0, 8'h01);
        run_pattern(0, 0, 8);
        drain(8);

        wb_write(1'b0, 8'h00);
        wb_write(1'b0, 8'h01);
        check("irq_pre", irq, 0);
        run_pattern(2, 0, 1);
        check("irq_first", irq, 1);
        run_pattern(2, 1, 7);
        drain(8);
        check("irq_alt_drained", irq, 0);

        wb_write(1'b0, 8'h00);
        wb_write(1'b0, 8'h01);
        run_pattern(1, 0, 9);
        wb_read(1'b0, d);
        check("st_ovf_raw", d, 8'h83);
        status_chk("st_ovf");
        wb_write(1'b0, 8'h03);
        mdl_ovf = 1'b0;
        status_chk("st_ovf_clr");
        drain(8);

        wb_write(1'b0, 8'h00);
        wb_write(1'b0, 8'h01);
        for (int i = 0; i < DECIM - 1; i++) strobe(1'b1);
        @(posedge clk); #1 pdm_en = 1'b1; pdm_data = 1'b1;
        @(posedge clk); #1 pdm_en = 1'b0;
        #1 rst = 1'b1; stb = 1'b1; adr = 1'b0;
        #2 check("rstc_status", rdat, 8'h00);
        check("rstc_irq", irq, 0);
        stb = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        repeat (10) @(posedge clk);
        status_chk("rstc_nopush");
        wb_write(1'b0, 8'h01);
        for (int i = 0; i < DECIM - 1; i++) strobe(1'b1);
        repeat (4) @(posedge clk);
        status_chk("rstc_63");
        strobe(1'b1);
        repeat (2) @(posedge clk);
        sb_push(-1);
        status_chk("rstc_64");
        drain(1);
        status_chk("rstc_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // First read after an empty-FIFO read must return the low byte of the head sample.
    function automatic logic [7:0] rdat_lo_ref(input logic [7:0] unused_d);
        int e;
        e = (exp_q.size() > 0) ? exp_q[0] : 0;
        return (e >= 0) ? e[7:0] : unused_d;
    endfunction

    task automatic drain_after_lo(input logic [7:0] lo);
        logic [7:0] hi;
        int e;
        wb_read(1'b1, hi);
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mdl_cnt--;
            if (e >= 0) check("pcm", {16'h0, hi, lo}, e);
        end
        drain(7);
    endtask

endmodule
